multicycle_controller: RTL

Sequencing controller for the team's multicycle RV32I datapath. Each cycle it reads the decoded instruction fields and the ALU `Zero` flag and drives every datapath enable and mux select. It walks each instruction through fetch, decode, execute, memory and writeback states, and absorbs the fixed read latency of the registered instruction and data memories. It contains the main decoder, ALU decoder, branch-condition logic and a read-wait counter.

---
 rtl/multicycle_controller_if.sv | 29 ++
 rtl/multicycle_controller.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: decoded instruction fields in, datapath controls out
interface multicycle_controller_if;
  logic [6:0] op_code;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       Zero;
  logic       adr_src;
  logic       mem_write;
  logic       IR_write;
  logic       reg_write;
  logic       PC_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] imm_src;
  logic [2:0] alu_control;
  logic       illegal_instr;
  logic       instr_retired;
  modport master (
    input  op_code, funct3, funct7, Zero,
    output adr_src, mem_write, IR_write, reg_write, PC_write, result_src,
           alu_src_a, alu_src_b, imm_src, alu_control, illegal_instr, instr_retired
  );
  modport slave (
    output op_code, funct3, funct7, Zero,
    input  adr_src, mem_write, IR_write, reg_write, PC_write, result_src,
           alu_src_a, alu_src_b, imm_src, alu_control, illegal_instr, instr_retired
  );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: RV32I multicycle FSM sequencing datapath enables and mux selects
module multicycle_controller #(
  parameter int READ_WAIT = 1
) (
  input logic clk,
  input logic reset,
  multicycle_controller_if.master bus
);
  localparam int CW = $clog2(READ_WAIT + 1);
  localparam logic [CW-1:0] LAST = CW'(READ_WAIT - 1);
  localparam logic [3:0] FETCH     = 4'd0;
  localparam logic [3:0] FETCH_IR  = 4'd1;
  localparam logic [3:0] DECODE    = 4'd2;
  localparam logic [3:0] MEM_ADR   = 4'd3;
  localparam logic [3:0] MEM_READ  = 4'd4;
  localparam logic [3:0] MEM_WAIT  = 4'd5;
  localparam logic [3:0] MEM_WRITE = 4'd6;
  localparam logic [3:0] MEM_WB    = 4'd7;
  localparam logic [3:0] EXEC_R    = 4'd8;
  localparam logic [3:0] EXEC_I    = 4'd9;
  localparam logic [3:0] ALU_WB    = 4'd10;
  localparam logic [3:0] BRANCH    = 4'd11;
  localparam logic [3:0] JAL       = 4'd12;
  localparam logic [3:0] JALR_CALC = 4'd13;
  localparam logic [3:0] JALR_JUMP = 4'd14;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  logic [3:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          f3_ok, r_ok, legal;
  logic [2:0]    alu_op, dec_imm, mem_imm;
  always_comb begin
    f3_ok = bus.funct3 inside {3'b000, 3'b111, 3'b110, 3'b100, 3'b010};
    r_ok = f3_ok && (bus.funct7 == 7'b0 || (bus.funct7 == 7'b0100000 && bus.funct3 == 3'b000));
    legal = (bus.op_code inside {OP_LOAD, OP_STORE, OP_JAL, OP_JALR, OP_AUIPC}) ||
            (bus.op_code == OP_R && r_ok) || (bus.op_code == OP_I && f3_ok) ||
            (bus.op_code == OP_BRANCH && bus.funct3[2:1] == 2'b00);
    // op_code[5] separates R-type from I-type, so SUB never applies to addi
    alu_op = bus.funct3 == 3'b000 ? {2'b00, bus.op_code[5] & bus.funct7[5]} :
             bus.funct3 == 3'b111 ? 3'b010 :
             bus.funct3 == 3'b110 ? 3'b011 :
             bus.funct3 == 3'b100 ? 3'b100 :
             bus.funct3 == 3'b010 ? 3'b101 : 3'b000;
    dec_imm = bus.op_code == OP_BRANCH ? 3'b010 :
              bus.op_code == OP_JAL    ? 3'b011 :
              bus.op_code == OP_AUIPC  ? 3'b100 :
              bus.op_code == OP_STORE  ? 3'b001 : 3'b000;
    mem_imm = bus.op_code[5] ? 3'b001 : 3'b000;
  end
  always_comb begin
    state_d = state_q;
    cnt_d = '0;
    case (state_q)
      FETCH: begin
        state_d = cnt_q == LAST ? FETCH_IR : FETCH;
        cnt_d = cnt_q == LAST ? '0 : cnt_q + 1'b1;
      end
      FETCH_IR: state_d = DECODE;
      DECODE: state_d = !legal ? FETCH :
                        bus.op_code inside {OP_LOAD, OP_STORE} ? MEM_ADR :
                        bus.op_code == OP_R      ? EXEC_R :
                        bus.op_code == OP_I      ? EXEC_I :
                        bus.op_code == OP_BRANCH ? BRANCH :
                        bus.op_code == OP_JAL    ? JAL :
                        bus.op_code == OP_JALR   ? JALR_CALC : ALU_WB;
      MEM_ADR: state_d = bus.op_code[5] ? MEM_WRITE : MEM_READ;
      MEM_READ: state_d = MEM_WAIT;
      MEM_WAIT: begin
        state_d = cnt_q == LAST ? MEM_WB : MEM_WAIT;
        cnt_d = cnt_q == LAST ? '0 : cnt_q + 1'b1;
      end
      EXEC_R, EXEC_I, JAL, JALR_JUMP: state_d = ALU_WB;
      JALR_CALC: state_d = JALR_JUMP;
      default: state_d = FETCH;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= FETCH;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  // Outputs stay at their zero defaults while reset is held low
  always_comb begin
    bus.adr_src = 1'b0;
    bus.mem_write = 1'b0;
    bus.IR_write = 1'b0;
    bus.reg_write = 1'b0;
    bus.PC_write = 1'b0;
    bus.result_src = 2'b00;
    bus.alu_src_a = 2'b00;
    bus.alu_src_b = 2'b00;
    bus.imm_src = 3'b000;
    bus.alu_control = 3'b000;
    bus.illegal_instr = 1'b0;
    bus.instr_retired = 1'b0;
    if (reset) begin
      case (state_q)
        FETCH_IR: begin
          bus.IR_write = 1'b1;
          bus.alu_src_b = 2'b10;
          bus.result_src = 2'b10;
          bus.PC_write = 1'b1;
        end
        DECODE: begin
          bus.alu_src_a = 2'b01;
          bus.alu_src_b = 2'b01;
          bus.imm_src = dec_imm;
          bus.illegal_instr = !legal;
        end
        MEM_ADR, MEM_READ, MEM_WAIT, MEM_WRITE: begin
          bus.alu_src_a = 2'b10;
          bus.alu_src_b = 2'b01;
          bus.imm_src = mem_imm;
          bus.adr_src = state_q != MEM_ADR;
          bus.mem_write = state_q == MEM_WRITE;
          bus.instr_retired = state_q == MEM_WRITE;
        end
        MEM_WB: begin
          bus.result_src = 2'b01;
          bus.reg_write = 1'b1;
          bus.instr_retired = 1'b1;
        end
        EXEC_R, EXEC_I: begin
          bus.alu_src_a = 2'b10;
          bus.alu_src_b = state_q == EXEC_I ? 2'b01 : 2'b00;
          bus.alu_control = alu_op;
        end
        ALU_WB: begin
          bus.reg_write = 1'b1;
          bus.instr_retired = 1'b1;
        end
        BRANCH: begin
          bus.alu_src_a = 2'b10;
          bus.alu_control = 3'b001;
          bus.PC_write = bus.funct3[0] ? !bus.Zero : bus.Zero;
          bus.instr_retired = 1'b1;
        end
        JAL, JALR_JUMP: begin
          bus.alu_src_a = 2'b01;
          bus.alu_src_b = 2'b10;
          bus.PC_write = 1'b1;
        end
        JALR_CALC: begin
          bus.alu_src_a = 2'b10;
          bus.alu_src_b = 2'b01;
        end
        default: ;
      endcase
    end
  end
endmodule
